// File: rtl/float_vector_accumulator_pkg.sv
// Shared definitions for the float vector accumulator: FSM state encoding
// and field-position helpers for the {sign, 8-bit exp, mantissa} format.
package float_vector_accumulator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ADD   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int EXP_W = 8;

  // Bit positions inside a word whose mantissa is mant_len bits wide
  function automatic int sign_idx(input int mant_len);
    return mant_len + EXP_W;
  endfunction

  function automatic int exp_hi(input int mant_len);
    return mant_len + EXP_W - 1;
  endfunction

  function automatic int exp_lo(input int mant_len);
    return mant_len;
  endfunction

  function automatic int mant_hi(input int mant_len);
    return mant_len - 1;
  endfunction

endpackage

// File: rtl/float_vector_accumulator_if.sv
// Operand-stream, result-stream and control signals of the float vector
// accumulator, bundled with a driver-side and a block-side modport.
interface float_vector_accumulator_if #(
  parameter int MANT_LEN = 23,
  parameter int CNT_W    = 8
);

  logic                  start;
  logic [CNT_W-1:0]      vec_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [MANT_LEN+8:0]   in_data;
  logic                  in_sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [MANT_LEN+8:0]   out_data;
  logic [CNT_W-1:0]      out_count;
  logic                  busy;

  modport master (
    output start, vec_len, in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );

  modport slave (
    input  start, vec_len, in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );

endinterface

// File: rtl/float_vector_accumulator_custonmized_add_sub.sv
// Combinational custom-format float adder/subtractor with truncating
// rounding; the exponent wraps mod 256 and is never range-checked.
module custonmized_add_sub
  import float_vector_accumulator_pkg::*;
#(
  parameter int FIRST_MANT_LEN  = 23,
  parameter int SECOND_MANT_LEN = 23,
  parameter int RESULT_MANT_LEN = 23
) (
  input  logic [FIRST_MANT_LEN+8:0]  first_element,
  input  logic [SECOND_MANT_LEN+8:0] second_element,
  input  logic                       add_sub,
  output logic [RESULT_MANT_LEN+8:0] result
);

  localparam int W12 = (FIRST_MANT_LEN > SECOND_MANT_LEN) ? FIRST_MANT_LEN : SECOND_MANT_LEN;
  localparam int W   = (W12 > RESULT_MANT_LEN) ? W12 : RESULT_MANT_LEN;
  localparam int FS  = sign_idx(FIRST_MANT_LEN);
  localparam int SS  = sign_idx(SECOND_MANT_LEN);

  logic         a_sign, b_sign;
  logic [7:0]   a_exp, b_exp;
  logic [W:0]   a_man, b_man;
  logic         swap;
  logic         big_sign;
  logic [7:0]   big_exp, small_exp, exp_diff;
  logic [W:0]   big_man, small_man, small_al;
  logic [W+1:0] sum;
  logic [7:0]   lz;
  logic         found;
  logic         res_zero;
  logic         res_sign;
  logic [7:0]   norm_exp;
  logic [W:0]   norm_man;
  logic         unused_norm;

  // Unpack both operands onto a common mantissa width with the hidden one restored
  always_comb begin
    a_sign = first_element[FS];
    a_exp  = first_element[exp_hi(FIRST_MANT_LEN) -: 8];
    a_man  = (W+1)'({1'b1, first_element[mant_hi(FIRST_MANT_LEN):0]}) << (W - FIRST_MANT_LEN);
    b_sign = second_element[SS] ^ add_sub;
    b_exp  = second_element[exp_hi(SECOND_MANT_LEN) -: 8];
    b_man  = (W+1)'({1'b1, second_element[mant_hi(SECOND_MANT_LEN):0]}) << (W - SECOND_MANT_LEN);
  end

  // Align the smaller magnitude, add or subtract, then renormalise
  always_comb begin
    swap      = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
    big_sign  = swap ? b_sign : a_sign;
    big_exp   = swap ? b_exp  : a_exp;
    big_man   = swap ? b_man  : a_man;
    small_exp = swap ? a_exp  : b_exp;
    small_man = swap ? a_man  : b_man;
    exp_diff  = big_exp - small_exp;
    small_al  = small_man >> exp_diff;

    sum      = '0;
    lz       = '0;
    found    = 1'b0;
    res_zero = 1'b0;
    res_sign = big_sign;
    norm_exp = big_exp;
    norm_man = big_man;

    if ((a_exp == 8'd0) && (b_exp == 8'd0)) begin
      res_zero = 1'b1;
    end else if (b_exp == 8'd0) begin
      res_sign = a_sign;
      norm_exp = a_exp;
      norm_man = a_man;
    end else if (a_exp == 8'd0) begin
      res_sign = b_sign;
      norm_exp = b_exp;
      norm_man = b_man;
    end else if (a_sign == b_sign) begin
      sum = {1'b0, big_man} + {1'b0, small_al};
      if (sum[W+1]) begin
        norm_man = sum[W+1:1];
        norm_exp = big_exp + 8'd1;
      end else begin
        norm_man = sum[W:0];
      end
    end else begin
      sum = {1'b0, big_man - small_al};
      for (int i = W; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 8'(W - i);
          found = 1'b1;
        end
      end
      res_zero = !found;
      norm_man = sum[W:0] << lz;
      norm_exp = big_exp - lz;
    end
  end

  assign result      = res_zero ? '0 : {res_sign, norm_exp, norm_man[W-1 -: RESULT_MANT_LEN]};
  assign unused_norm = ^norm_man;

endmodule

// File: rtl/float_vector_accumulator.sv
// Sequential reduction of a stream of custom-format floats into a single sum,
// one element per FETCH/ADD pair, result held until downstream accepts it.
module float_vector_accumulator
  import float_vector_accumulator_pkg::*;
#(
  parameter int MANT_LEN = 23,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  float_vector_accumulator_if.slave bus
);

  localparam int DW   = MANT_LEN + 9;
  localparam int SIGN = sign_idx(MANT_LEN);

  logic [1:0]       state;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    op;
  logic             acc_zero;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt_next;
  logic [DW-1:0]    core_sum;

  custonmized_add_sub #(
    .FIRST_MANT_LEN  (MANT_LEN),
    .SECOND_MANT_LEN (MANT_LEN),
    .RESULT_MANT_LEN (MANT_LEN)
  ) u_core (
    .first_element  (acc),
    .second_element (op),
    .add_sub        (1'b0),
    .result         (core_sum)
  );

  assign cnt_next = cnt + CNT_W'(1);

  // FSM and datapath; zero operands and exact cancellation bypass the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc      <= '0;
      op       <= '0;
      acc_zero <= 1'b1;
      cnt      <= '0;
      len      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            len      <= bus.vec_len;
            cnt      <= '0;
            acc_zero <= 1'b1;
            state    <= (bus.vec_len == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.in_valid) begin
            op    <= {bus.in_data[SIGN] ^ bus.in_sub, bus.in_data[SIGN-1:0]};
            state <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (op[exp_hi(MANT_LEN) -: 8] != 8'd0) begin
            if (acc_zero) begin
              acc      <= op;
              acc_zero <= 1'b0;
            end else if ((op[SIGN-1:0] == acc[SIGN-1:0]) && (op[SIGN] != acc[SIGN])) begin
              acc      <= '0;
              acc_zero <= 1'b1;
            end else begin
              acc <= core_sum;
            end
          end
          cnt   <= cnt_next;
          state <= (cnt_next == len) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without a clock
  always_comb begin
    bus.in_ready  = (state == ST_FETCH);
    bus.out_valid = (state == ST_DONE);
    bus.busy      = (state != ST_IDLE);
    bus.out_data  = '0;
    bus.out_count = '0;
    if (state == ST_DONE) begin
      bus.out_data  = acc_zero ? '0 : acc;
      bus.out_count = cnt;
    end
  end

endmodule

// File: tb/tb_float_vector_accumulator.sv
// Directed self-checking bench for float_vector_accumulator (MANT_LEN=23).
module tb_float_vector_accumulator;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  float_vector_accumulator_if #(.MANT_LEN(23), .CNT_W(8)) bus ();

  float_vector_accumulator #(.MANT_LEN(23), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one element and hold it until the block accepts it (bounded)
  task automatic send_elem(input logic [31:0] d, input logic s, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sub   = s;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_sub   = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    ok = bus.out_valid;
  endtask

  task automatic run_reduction(input logic [7:0] len, input logic [95:0] d, input logic [2:0] s,
                               output logic [31:0] data, output logic [7:0] count,
                               output int lat, output bit ok);
    bit e_ok;
    ok = 1'b1;
    bus.start   = 1'b1;
    bus.vec_len = len;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      send_elem(d[32*i +: 32], s[i], e_ok);
      ok = ok & e_ok;
    end
    wait_done(lat, e_ok);
    ok    = ok & e_ok;
    data  = bus.out_data;
    count = bus.out_count;
  endtask

  task automatic finish_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.in_ready, bus.out_valid, bus.busy});
    end
    compared++;
    if (bus.out_data !== 32'h0 || bus.out_count !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h/%0d expected 0/0", bus.out_data, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    run_reduction(8'd2, {32'h0, 32'h40000000, 32'h3F800000}, 3'b000, data, count, lat, ok);
    compared++;
    if (!ok) begin mismatched++; $display("[TB] FAIL add_handshake: timed out, got 0 expected 1"); end
    compared++;
    if (data !== 32'h40400000) begin mismatched++; $display("[TB] FAIL add_data: got %h expected 40400000", data); end
    compared++;
    if (count !== 8'd2) begin mismatched++; $display("[TB] FAIL add_count: got %0d expected 2", count); end
    compared++;
    if (lat !== 1) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
    finish_result();
    compared++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL add_release: got valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_sub();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    run_reduction(8'd2, {32'h0, 32'h3F800000, 32'h40400000}, 3'b010, data, count, lat, ok);
    compared++;
    if (!ok || data !== 32'h40000000) begin
      mismatched++;
      $display("[TB] FAIL sub_data: got %h ok=%b expected 40000000", data, ok);
    end
    finish_result();
  endtask

  task automatic test_cancel();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    run_reduction(8'd2, {32'h0, 32'h3F800000, 32'h3F800000}, 3'b010, data, count, lat, ok);
    compared++;
    if (!ok || data !== 32'h00000000) begin
      mismatched++;
      $display("[TB] FAIL cancel_data: got %h ok=%b expected 00000000", data, ok);
    end
    compared++;
    if (count !== 8'd2) begin mismatched++; $display("[TB] FAIL cancel_count: got %0d expected 2", count); end
    finish_result();
  endtask

  task automatic test_zero_skip();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    run_reduction(8'd3, {32'h3F000000, 32'h00000000, 32'h3F800000}, 3'b000, data, count, lat, ok);
    compared++;
    if (!ok || data !== 32'h3FC00000) begin
      mismatched++;
      $display("[TB] FAIL zero_skip_data: got %h ok=%b expected 3fc00000", data, ok);
    end
    compared++;
    if (count !== 8'd3) begin mismatched++; $display("[TB] FAIL zero_skip_count: got %0d expected 3", count); end
    finish_result();
  endtask

  task automatic test_len_zero();
    bus.start   = 1'b1;
    bus.vec_len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    compared++;
    if (bus.out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_valid: got %b expected 1", bus.out_valid); end
    compared++;
    if (bus.out_data !== 32'h0 || bus.out_count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL len0_result: got %h/%0d expected 0/0", bus.out_data, bus.out_count);
    end
    compared++;
    if (bus.in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_in_ready: got %b expected 0", bus.in_ready); end
    finish_result();
  endtask

  task automatic test_backpressure();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    int bad;
    run_reduction(8'd2, {32'h0, 32'h40000000, 32'h3F800000}, 3'b000, data, count, lat, ok);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.start   = (i == 2);
      bus.vec_len = 8'd5;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h40400000 || bus.in_ready !== 1'b0) bad++;
    end
    bus.start = 1'b0;
    compared++;
    if (bad != 0 || !ok) begin
      mismatched++;
      $display("[TB] FAIL backpressure_hold: got %0d unstable cycles ok=%b expected 0", bad, ok);
    end
    finish_result();
    compared++;
    if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL backpressure_start_ignored: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] data; logic [7:0] count; int lat; bit ok;
    bus.start   = 1'b1;
    bus.vec_len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    send_elem(32'h3F800000, 1'b0, ok);
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1 || !ok) begin mismatched++; $display("[TB] FAIL midreset_fetch: got in_ready=%b expected 1", bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000 || bus.out_data !== 32'h0 || bus.out_count !== 8'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs: got %b %h %0d expected 000 0 0",
               {bus.in_ready, bus.out_valid, bus.busy}, bus.out_data, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_reduction(8'd2, {32'h0, 32'h40000000, 32'h3F800000}, 3'b000, data, count, lat, ok);
    compared++;
    if (!ok || data !== 32'h40400000 || count !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL midreset_clean: got %h/%0d expected 40400000/2", data, count);
    end
    finish_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] data; logic [7:0] count; int lat; bit ok, e_ok;
    run_reduction(8'd1, {32'h0, 32'h0, 32'h3F800000}, 3'b000, data, count, lat, ok);
    compared++;
    if (!ok || data !== 32'h3F800000 || count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %h/%0d expected 3f800000/1", data, count);
    end
    finish_result();
    bus.start   = 1'b1;
    bus.vec_len = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    compared++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept: got busy=%b in_ready=%b expected 1/1", bus.busy, bus.in_ready);
    end
    send_elem(32'h40000000, 1'b0, ok);
    send_elem(32'h40000000, 1'b0, e_ok);
    ok = ok & e_ok;
    wait_done(lat, e_ok);
    compared++;
    if (!(ok & e_ok) || bus.out_data !== 32'h40800000 || bus.out_count !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got %h/%0d expected 40800000/2", bus.out_data, bus.out_count);
    end
    finish_result();
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.vec_len   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_cancel();
    test_zero_skip();
    test_len_zero();
    test_backpressure();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
